// File: rtl/vec_norm_dot_engine.sv
// rtl/vec_norm_dot_engine.sv - two-bank streaming sum(a*a)/sum(a*b) engine with saturating accumulator
// Host owns both banks while idle; the engine owns them from the clk after start until done.
module vec_norm_dot_engine #(
    parameter int DATA_W = 27,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_enable,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        init_i,
    input  logic [ADDR_W:0]          init_len,
    input  logic signed [ACC_W-1:0]  init_acc,
    input  logic                     controlArr,
    input  logic                     controlArrSel,
    input  logic                     controlArrWEnable,
    input  logic [ADDR_W-1:0]        controlArrAddr,
    input  logic signed [DATA_W-1:0] controlArrWData,
    output logic signed [DATA_W-1:0] controlArrRData,
    output logic                     busy,
    output logic                     w_enable,
    output logic signed [ACC_W-1:0]  result,
    output logic                     overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_d;
    logic start;

    logic signed [DATA_W-1:0] mem_a [DEPTH];
    logic signed [DATA_W-1:0] mem_b [DEPTH];
    logic signed [DATA_W-1:0] a_q, b_q;

    logic                     mode_q;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W:0]          remaining;
    logic                     drain_cnt;
    logic                     rd_valid, prod_valid;
    logic signed [PROD_W-1:0] prod, a_ext, b_ext;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic signed [ACC_W:0]    sum_w;
    logic                     add_ovf;

    logic                     host_ok, host_wr, host_rd, rd_en;
    logic                     host_rd_q, host_sel_q;
    logic [ADDR_W-1:0]        rd_addr;

    always_comb begin
        state_d  = state;
        busy     = 1'b0;
        w_enable = 1'b0;
        start    = 1'b0;
        case (state)
            IDLE: begin
                start = r_enable;
                if (r_enable) state_d = (init_len == '0) ? DRAIN : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (remaining == (ADDR_W+1)'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_d = DONE;
            end
            DONE: begin
                w_enable = 1'b1;
                start    = r_enable;
                if (r_enable) state_d = (init_len == '0) ? DRAIN : RUN;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Host traffic is only honoured while the engine is not streaming.
    assign host_ok = controlArr && !busy && (controlArrAddr <= LAST_ADDR);
    assign host_wr = host_ok && controlArrWEnable;
    assign host_rd = host_ok && !controlArrWEnable;
    assign rd_en   = (state == RUN) || host_rd;
    assign rd_addr = (state == RUN) ? idx : controlArrAddr;

    always_ff @(posedge clk) begin
        if (host_wr && !controlArrSel) mem_a[controlArrAddr] <= controlArrWData;
        if (host_wr &&  controlArrSel) mem_b[controlArrAddr] <= controlArrWData;
        if (rd_en) begin
            a_q <= mem_a[rd_addr];
            b_q <= mem_b[rd_addr];
        end
    end

    assign controlArrRData = host_rd_q ? (host_sel_q ? b_q : a_q) : '0;

    assign a_ext = PROD_W'(a_q);
    assign b_ext = PROD_W'(mode_q ? b_q : a_q);

    // One extra bit of headroom exposes signed overflow as a mismatch of the top two bits.
    assign sum_w    = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    assign add_ovf  = sum_w[ACC_W] != sum_w[ACC_W-1];
    assign acc_next = !prod_valid ? acc :
                      add_ovf     ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) :
                                    sum_w[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            idx        <= '0;
            remaining  <= '0;
            drain_cnt  <= 1'b0;
            rd_valid   <= 1'b0;
            prod_valid <= 1'b0;
            prod       <= '0;
            acc        <= '0;
            overflow   <= 1'b0;
            result     <= '0;
            host_rd_q  <= 1'b0;
            host_sel_q <= 1'b0;
        end else begin
            state      <= state_d;
            host_rd_q  <= host_rd;
            host_sel_q <= controlArrSel;
            rd_valid   <= (state == RUN);
            prod_valid <= rd_valid;
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (rd_valid) prod <= a_ext * b_ext;
            if (start) begin
                mode_q    <= mode;
                idx       <= init_i;
                remaining <= init_len;
                acc       <= init_acc;
                overflow  <= 1'b0;
            end else if (prod_valid) begin
                acc <= acc_next;
                if (add_ovf) overflow <= 1'b1;
            end
            if (state == RUN) begin
                idx       <= (idx == LAST_ADDR) ? '0 : idx + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            if (state == DRAIN && drain_cnt) result <= acc_next;
        end
    end

endmodule

// File: tb/tb_vec_norm_dot_engine.sv
// tb/tb_vec_norm_dot_engine.sv - self-checking bench for vec_norm_dot_engine
module tb_vec_norm_dot_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               r_enable;
    logic               mode;
    logic [9:0]         init_i;
    logic [10:0]        init_len;
    logic signed [63:0] init_acc;
    logic               controlArr;
    logic               controlArrSel;
    logic               controlArrWEnable;
    logic [9:0]         controlArrAddr;
    logic signed [26:0] controlArrWData;
    logic signed [26:0] controlArrRData;
    logic               busy;
    logic               w_enable;
    logic signed [63:0] result;
    logic               overflow;

    vec_norm_dot_engine dut (
        .clk(clk), .rst(rst), .r_enable(r_enable), .mode(mode),
        .init_i(init_i), .init_len(init_len), .init_acc(init_acc),
        .controlArr(controlArr), .controlArrSel(controlArrSel),
        .controlArrWEnable(controlArrWEnable), .controlArrAddr(controlArrAddr),
        .controlArrWData(controlArrWData), .controlArrRData(controlArrRData),
        .busy(busy), .w_enable(w_enable), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e = 0;
    always @(posedge clk) e <= e + 1;

    typedef struct {
        longint res;
        logic   ovf;
        int     edge_n;
    } ev_t;

    ev_t sb[$];
    ev_t obs[$];

    always @(negedge clk) if (w_enable) obs.push_back('{result, overflow, e});

    typedef struct {
        logic   w0_en; logic w0_sel; int w0_addr; longint w0_data;
        logic   w1_en; logic w1_sel; int w1_addr; longint w1_data;
        logic   m; int i; int len; longint acc;
        longint exp_res; logic exp_ovf;
    } vec_t;

    vec_t vecs[7];
    longint ma[1000];
    longint mb[1000];

    localparam longint P63M10 = 64'h7FFF_FFFF_FFFF_FFF6;
    localparam longint P63M1  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam longint P63M13 = 64'h7FFF_FFFF_FFFF_FFF3;
    localparam longint N63P5  = 64'h8000_0000_0000_0005;
    localparam longint N63    = 64'h8000_0000_0000_0000;
    localparam longint DMAX   = 67108863;
    localparam longint DMIN   = -67108864;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model(input logic m, input int i, input int len, input longint acc0,
                                  output longint res, output logic ovf);
        logic signed [127:0] s, hi, lo, p;
        int idx;
        hi = 128'(P63M1);
        lo = -hi - 1;
        s = 128'(acc0);
        idx = i;
        ovf = 1'b0;
        for (int k = 0; k < len; k++) begin
            p = 128'(ma[idx] * (m ? mb[idx] : ma[idx]));
            s = s + p;
            if (s > hi) begin s = hi; ovf = 1'b1; end
            if (s < lo) begin s = lo; ovf = 1'b1; end
            idx = (idx + 1) % 1000;
        end
        res = s[63:0];
    endfunction

    function automatic vec_t mk(input logic w0e, input logic w0s, input int w0a, input longint w0d,
                                input logic w1e, input logic w1s, input int w1a, input longint w1d,
                                input logic m, input int i, input int len, input longint acc,
                                input longint er, input logic eo);
        vec_t v;
        v.w0_en = w0e; v.w0_sel = w0s; v.w0_addr = w0a; v.w0_data = w0d;
        v.w1_en = w1e; v.w1_sel = w1s; v.w1_addr = w1a; v.w1_data = w1d;
        v.m = m; v.i = i; v.len = len; v.acc = acc; v.exp_res = er; v.exp_ovf = eo;
        return v;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic host_write(input logic sel, input int addr, input longint data, input logic commit);
        controlArr = 1'b1; controlArrWEnable = 1'b1; controlArrSel = sel;
        controlArrAddr = addr[9:0]; controlArrWData = data[26:0];
        @(posedge clk); #1;
        controlArr = 1'b0; controlArrWEnable = 1'b0;
        if (commit && addr < 1000) begin
            if (sel) mb[addr] = data; else ma[addr] = data;
        end
    endtask

    task automatic host_read(input logic sel, input int addr, input longint exp, input string name);
        controlArr = 1'b1; controlArrWEnable = 1'b0; controlArrSel = sel; controlArrAddr = addr[9:0];
        @(posedge clk); #1;
        controlArr = 1'b0;
        chk(name, longint'(controlArrRData), exp);
    endtask

    task automatic start_run(input logic m, input int i, input int len, input longint acc,
                             input longint er, input logic eo);
        r_enable = 1'b1; mode = m; init_i = i[9:0]; init_len = len[10:0]; init_acc = acc;
        @(posedge clk); #1;
        r_enable = 1'b0;
        sb.push_back('{er, eo, e + len + 2});
    endtask

    task automatic wait_done(input string name);
        int n;
        ev_t o, x;
        n = 0;
        while (obs.size() == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (obs.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_w_enable expected=w_enable", name);
        end else if (sb.size() == 0) begin
            checks++; errors++;
            void'(obs.pop_front());
            $display("FAIL %s_unexpected actual=w_enable expected=none", name);
        end else begin
            o = obs.pop_front();
            x = sb.pop_front();
            chk({name, "_result"}, o.res, x.res);
            chk({name, "_overflow"}, longint'(o.ovf), longint'(x.ovf));
            chk({name, "_cycle"}, longint'(o.edge_n), longint'(x.edge_n));
        end
    endtask

    initial begin
        longint r;
        logic o;
        int v;

        rst = 1'b1; r_enable = 1'b0; mode = 1'b0; init_i = '0; init_len = '0; init_acc = '0;
        controlArr = 1'b0; controlArrSel = 1'b0; controlArrWEnable = 1'b0;
        controlArrAddr = '0; controlArrWData = '0;
        for (int k = 0; k < 1000; k++) begin ma[k] = 0; mb[k] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_busy", longint'(busy), 0);
        chk("rst_w_enable", longint'(w_enable), 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_rdata", longint'(controlArrRData), 0);

        host_write(0, 0, 1, 1);  host_write(0, 1, -2, 1);
        host_write(0, 2, 3, 1);  host_write(0, 3, 4, 1);
        host_write(1, 0, 5, 1);  host_write(1, 1, 6, 1);
        host_write(1, 2, -7, 1); host_write(1, 3, 8, 1);
        host_write(0, 998, 2, 1); host_write(0, 999, 3, 1);
        host_write(0, 1000, 55, 0);
        host_read(0, 1, -2, "rd_a1");
        host_read(1, 2, -7, "rd_b2");
        host_read(0, 999, 3, "rd_a999");
        host_read(0, 1000, 0, "rd_oob");

        vecs[0] = mk(0,0,0,0, 0,0,0,0,          0, 0,   4, 0,     30,     0);
        vecs[1] = mk(0,0,0,0, 0,0,0,0,          1, 0,   4, 100,   104,    0);
        vecs[2] = mk(1,0,0,4, 0,0,0,0,          0, 998, 3, 0,     29,     0);
        vecs[3] = mk(1,0,0,DMAX, 0,0,0,0,       0, 0,   1, P63M10, P63M1, 1);
        vecs[4] = mk(0,0,0,0, 0,0,0,0,          0, 5,   0, -7,    -7,     0);
        vecs[5] = mk(1,0,0,DMAX, 1,1,0,DMAX,    1, 0,   2, P63M10, P63M13, 1);
        vecs[6] = mk(1,0,0,DMIN, 1,1,0,DMAX,    1, 0,   1, N63P5, N63,    1);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].w0_en) host_write(vecs[k].w0_sel, vecs[k].w0_addr, vecs[k].w0_data, 1);
            if (vecs[k].w1_en) host_write(vecs[k].w1_sel, vecs[k].w1_addr, vecs[k].w1_data, 1);
            start_run(vecs[k].m, vecs[k].i, vecs[k].len, vecs[k].acc, vecs[k].exp_res, vecs[k].exp_ovf);
            wait_done($sformatf("vec%0d", k));
        end

        // Start and host write attempted mid-run must both be ignored.
        model(0, 0, 4, 0, r, o);
        start_run(0, 0, 4, 0, r, o);
        r_enable = 1'b1; init_len = '0; init_acc = 123;
        controlArr = 1'b1; controlArrWEnable = 1'b1; controlArrSel = 1'b0;
        controlArrAddr = 10'd2; controlArrWData = 27'sd999;
        @(posedge clk); #1;
        r_enable = 1'b0; controlArrWEnable = 1'b0; controlArrAddr = 10'd1;
        @(posedge clk); #1;
        controlArr = 1'b0;
        chk("rd_busy", longint'(controlArrRData), 0);
        wait_done("midrun");
        host_read(0, 2, 3, "mem_kept");

        // Host write together with start in IDLE, then a restart in the DONE cycle.
        controlArr = 1'b1; controlArrWEnable = 1'b1; controlArrSel = 1'b1;
        controlArrAddr = 10'd500; controlArrWData = 27'sd77;
        mb[500] = 77;
        model(1, 0, 2, -5, r, o);
        start_run(1, 0, 2, -5, r, o);
        controlArr = 1'b0; controlArrWEnable = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("done_strobe", longint'(w_enable), 1);
        chk("done_not_busy", longint'(busy), 0);
        model(0, 998, 3, 1, r, o);
        start_run(0, 998, 3, 1, r, o);
        wait_done("b2b_first");
        wait_done("b2b_second");
        host_read(1, 500, 77, "rd_b500");

        // Full-depth run aborted by reset, then rerun without reloading.
        for (int k = 0; k < 1000; k++) begin
            v = $signed($urandom) >>> 5;
            host_write(0, k, longint'(v), 1);
        end
        model(0, 7, 1000, -1000, r, o);
        start_run(0, 7, 1000, -1000, r, o);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", longint'(busy), 0);
        chk("abort_w_enable", longint'(w_enable), 0);
        chk("abort_result", result, 0);
        chk("abort_overflow", longint'(overflow), 0);
        repeat (1010) begin @(posedge clk); #1; end
        chk("abort_no_done", longint'(obs.size()), 0);
        start_run(0, 7, 1000, -1000, r, o);
        wait_done("rerun");

        repeat (5) begin @(posedge clk); #1; end
        chk("no_extra_done", longint'(obs.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
